fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction buffer between the fetch stage and the decode stage of the 5-stage core.
- Decouples fetch from decode using a valid/ready handshake on both sides.
- Absorbs decode back-pressure and discards wrong-path instructions on a branch flush.
- Removes the need for the post-reset decode-stall flop: decode sees nothing until a real fetch has been pushed.

Parameters:
- IW, 32: instruction width in bits.
- AW, 32: PC width in bits.
- DEPTH, 4: number of entries; a power of two, at least 2.
- DROP_CW, 16: width of the saturating flush-drop statistic counter.

Ports:
- clk, input, 1: rising-edge clock.
- nrst, input, 1: reset, asynchronous assert, active-low.
- flush, input, 1: synchronous flush from PC generation (branch taken).
- in_valid, input, 1: fetch presents an instruction.
- in_ready, output, 1: queue can accept an instruction.
- in_instr, input, IW: fetched instruction.
- in_pc, input, AW: PC of the fetched instruction.
- out_valid, output, 1: head entry available to decode.
- out_ready, input, 1: decode consumes the head this cycle.
- out_instr, output, IW: head instruction; all-zero (NOP) when empty.
- out_pc, output, AW: head PC; zero when empty.
- count, output, $clog2(DEPTH+1): current occupancy.
- flush_drops, output, DROP_CW: total entries discarded by flushes; saturates at all-ones.

Behaviour:
- Reset (nrst low, asynchronous) clears, independent of clk:
  - read and write pointers = 0, count = 0, flush_drops = 0;
  - out_valid = 0, out_instr = 0, out_pc = 0, in_ready = 1 once nrst is released.
- Reset mid-operation drops all contents immediately; storage contents are don't-care.
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH):
  - registered-state based only, no combinational path from out_ready;
  - a full queue refuses a push even when a pop occurs the same cycle.
- Push writes mem[wptr] and advances wptr at the clock edge.
- Pop advances rptr.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop, which is legal whenever 0 < count < DEPTH.
- Latency: an instruction pushed at edge N is visible at the outputs (out_valid = 1) after edge N. There is no same-cycle bypass when empty.
- Outputs are driven from mem[rptr] when count != 0. When count == 0, out_valid = 0 and out_instr/out_pc are forced to 0.
- Ordering is strict FIFO: no reordering, no duplication, no loss except on flush.
- flush (synchronous, highest priority over push and pop):
  - on the edge, rptr = wptr = 0 and count = 0;
  - a push or pop presented in the flush cycle is ignored; the pushed instruction is discarded;
  - flush_drops += count (pre-flush occupancy), plus 1 if a push was presented that cycle; saturates at 2^DROP_CW-1;
  - the cycle after a flush: out_valid = 0, in_ready = 1.
- Back-to-back flushes are legal; each one accumulates its own drops.
- Empty queue with out_ready = 1: no pop, count stays 0, no underflow.
- Full queue with in_valid = 1: no write, no pointer movement, no overflow.
- No internal state machine beyond the pointer/count state; occupancy is the state.

Decomposition:
- Shared core package (cpu_pkg) holds:
  - XLEN = 32 and instruction width constant;
  - NOP encoding (all zeros), shared with decode flush logic;
  - helper function for pointer width.
- One natural sub-module: fetch_queue_mem.
  - DEPTH x (IW+AW) register array;
  - one synchronous write port, one asynchronous read port;
  - no reset on storage.

Test Plan:
- Reset then idle: nrst low for 3 cycles, release, no input -> count=0, out_valid=0, out_instr=0, in_ready=1, flush_drops=0.
- Fill and drain, DEPTH=4, out_ready=0:
  - push PCs 0x00,0x04,0x08,0x0C -> count=4, in_ready=0;
  - a fifth push of 0x10 is refused;
  - raise out_ready -> outputs 0x00,0x04,0x08,0x0C in order over 4 cycles, then out_valid=0.
- Streaming: in_valid=out_ready=1 continuously for 20 instructions after the first push -> count stays 1, every PC delivered exactly once in order, pointers wrap at least 4 times.
- Flush with contents: 3 entries queued, flush asserted while pushing 0x40 -> next cycle count=0, out_valid=0, flush_drops=4; the next push 0x80 appears as the head one cycle later.
- Saturation: DROP_CW=3, repeated full-queue flushes with a push (5 drops each) -> flush_drops goes 5, then 7, and stays 7.
- Asynchronous reset mid-stream: nrst pulled low between clock edges with count=2 -> out_valid and count go to 0 before the next edge; no stale entry appears after release.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Constants and helpers shared across the 5-stage core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // All-zero encoding is treated as a NOP by decode and its flush logic.
  localparam logic [ILEN-1:0] NOP = '0;

  // Width of a pointer indexing a buffer of the given depth (never below 1).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_mem
// Description : DEPTH x W register array, one synchronous write port and one
//               asynchronous read port. Storage is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_mem #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction buffer between fetch and decode. Valid/ready on
//               both sides, strict FIFO order, synchronous flush that discards
//               all contents and counts the discarded entries (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int IW      = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 4,
  parameter int DROP_CW = 16
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW-1:0]              in_instr,
  input  logic [AW-1:0]              in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW-1:0]              out_instr,
  output logic [AW-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DROP_CW-1:0]         flush_drops
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = IW + AW;
  // Drop sum is formed one bit wider than its widest operand so the
  // saturation compare sees any carry.
  localparam int SW = ((DROP_CW > CW) ? DROP_CW : CW) + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] DROP_MAX = SW'({DROP_CW{1'b1}});

  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DROP_CW-1:0] drops_q, drops_d;

  logic          w_push;
  logic          w_pop;
  logic          w_we;
  logic [DW-1:0] w_rdata;
  logic [SW-1:0] w_drop_sum;

  // Readiness depends on registered occupancy only, so a full queue refuses
  // a push even if decode pops in the same cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;
  assign w_we   = w_push && !flush;

  // A presented instruction counts as dropped on flush even if the queue
  // was full and would not have accepted it.
  assign w_drop_sum = SW'(drops_q) + SW'(count_q) + SW'(in_valid);

  fetch_queue_mem #(
    .W     (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (wptr_q),
    .wdata_i ({in_pc, in_instr}),
    .raddr_i (rptr_q),
    .rdata_o (w_rdata)
  );

  // Next-state for pointers, occupancy and drop statistic; flush wins.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    drops_d = drops_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      drops_d = (w_drop_sum > DROP_MAX) ? DROP_MAX[DROP_CW-1:0]
                                        : w_drop_sum[DROP_CW-1:0];
    end else begin
      if (w_push) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (w_pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (w_push && !w_pop) begin
        count_d = count_q + CW'(1);
      end else if (w_pop && !w_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drops_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drops_q <= drops_d;
    end
  end

  // Head is presented only when occupied; otherwise decode sees a NOP at PC 0.
  assign out_instr   = out_valid ? w_rdata[IW-1:0]  : IW'(NOP);
  assign out_pc      = out_valid ? w_rdata[DW-1:IW] : '0;
  assign count       = count_q;
  assign flush_drops = drops_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Scoreboard bench for fetch_queue: a queue-based reference
//               model of the buffer plus a monitor comparing every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int IW      = 32;
  localparam int AW      = 32;
  localparam int DEPTH   = 4;
  localparam int DROP_CW = 3;
  localparam int DMAX    = 7;

  logic          clk = 1'b0;
  logic          nrst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [2:0]    count;
  logic [DROP_CW-1:0] flush_drops;

  fetch_queue #(
    .IW (IW), .AW (AW), .DEPTH (DEPTH), .DROP_CW (DROP_CW)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count),
    .flush_drops (flush_drops)
  );

  always #5 clk = ~clk;

  // Reference model: contents in order ({pc, instr}) and the drop statistic.
  logic [63:0] exp_q[$];
  int          drops_m = 0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle after inputs settle, compare DUT to model, then retire
  // the head if decode takes it this cycle.
  initial begin
    int sz;
    forever begin
      @(negedge clk);
      #2;
      sz = exp_q.size();
      chk("count", 64'(count), 64'(sz));
      chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(sz != 0));
      chk("flush_drops", 64'(flush_drops), 64'(drops_m));
      if (sz != 0) begin
        chk("head", {out_pc, out_instr}, exp_q[0]);
        if (out_ready && !flush && nrst) void'(exp_q.pop_front());
      end else begin
        chk("nop_instr", 64'(out_instr), 64'd0);
        chk("nop_pc", 64'(out_pc), 64'd0);
      end
    end
  end

  // One clock of stimulus; the model is updated after the monitor has run.
  task automatic cycle(input logic iv, input logic fl, input logic ordy,
                       input logic [AW-1:0] pc, input logic [IW-1:0] instr);
    bit full_before;
    @(negedge clk);
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    in_pc     = pc;
    in_instr  = instr;
    full_before = (exp_q.size() == DEPTH);
    #4;
    if (fl) begin
      drops_m = drops_m + exp_q.size() + (iv ? 1 : 0);
      if (drops_m > DMAX) drops_m = DMAX;
      exp_q.delete();
    end else if (iv && !full_before) begin
      exp_q.push_back({pc, instr});
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, ordy, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    nrst = 1'b0;
    exp_q.delete();
    drops_m = 0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic fill(input int n, input logic [AW-1:0] base);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'b0, 1'b0, base + AW'(4 * i), $urandom);
  endtask

  initial begin
    nrst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    idle(3, 1'b0);

    // Fill to full, refused fifth push, then drain in order.
    fill(4, 32'h00);
    cycle(1'b1, 1'b0, 1'b0, 32'h10, 32'hdead_beef);
    idle(6, 1'b1);

    // Streaming with simultaneous push and pop.
    cycle(1'b1, 1'b0, 1'b0, 32'h100, $urandom);
    for (int i = 1; i <= 20; i++)
      cycle(1'b1, 1'b0, 1'b1, 32'h100 + AW'(4 * i), $urandom);
    idle(3, 1'b1);

    // Flush with three entries plus a presented push.
    fill(3, 32'h20);
    cycle(1'b1, 1'b1, 1'b0, 32'h40, $urandom);
    cycle(1'b1, 1'b0, 1'b0, 32'h80, $urandom);
    idle(3, 1'b1);

    // Saturation of the drop counter.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fill(4, 32'h200);
      cycle(1'b1, 1'b1, 1'b0, 32'h300, $urandom);
    end
    idle(2, 1'b1);

    // Asynchronous reset between edges with two entries queued.
    fill(2, 32'h400);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #3 nrst = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    drops_m = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    idle(4, 1'b1);

    // Randomized traffic, re-arming the drop statistic per chunk.
    for (int c = 0; c < 4; c++) begin
      do_reset();
      for (int i = 0; i < 150; i++)
        cycle($urandom_range(99) < 70, $urandom_range(99) < 5,
              $urandom_range(99) < 60, $urandom & 32'hffff_fffc, $urandom);
      idle(6, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
